mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: drives the pipelined core's data-memory bus for loads/stores

---
 rtl/mem_stage_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack data bus master with byte/half/word sizing,
// load extension, pipeline stall and bus timeout. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
`timescale 1ns/1ps

module mem_stage_lsu #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             MisalignM,
  output logic             BusErrM,
  output logic             DReq,
  output logic             DWe,
  output logic [WIDTH-1:0] DAddr,
  output logic [WIDTH-1:0] DWData,
  output logic [3:0]       DStrb,
  input  logic             DAck,
  input  logic [WIDTH-1:0] DRData
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             dreq_q, dreq_d;
  logic             dwe_q, dwe_d;
  logic [WIDTH-1:0] daddr_q, daddr_d;
  logic [WIDTH-1:0] dwdata_q, dwdata_d;
  logic [3:0]       dstrb_q, dstrb_d;
  logic [WIDTH-1:0] rbuf_q, rbuf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             buserr_q, buserr_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [1:0]       off_q, off_d;
  logic             isload_q, isload_d;

  logic             req_any;
  logic             is_byte;
  logic             is_half;
  logic             misaligned;
  logic             acc;
  logic [1:0]       off;
  logic [WIDTH-1:0] st_data;
  logic [3:0]       st_strb;

  assign req_any = MemReadM | MemWriteM;
  assign off     = ALUResultM[1:0];
  assign is_byte = (Funct3M[1:0] == SZ_BYTE);
  assign is_half = (Funct3M[1:0] == SZ_HALF);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
  assign MisalignM  = req_any & misaligned;
`else
  // Without trapping, sub-word offset bits that don't fit the size are simply dropped.
  assign misaligned = 1'b0;
  assign MisalignM  = 1'b0;
`endif

  assign acc    = req_any & ~misaligned;
  assign StallM = acc & (state_q != S_DONE);

  always_comb begin
    st_data = WriteDataM;
    st_strb = 4'hF;
    if (is_byte) begin
      st_data = {4{WriteDataM[7:0]}};
      st_strb = 4'b0001 << off;
    end else if (is_half) begin
      st_data = {2{WriteDataM[15:0]}};
      st_strb = off[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dstrb_d  = dstrb_q;
    rbuf_d   = rbuf_q;
    cnt_d    = cnt_q;
    buserr_d = buserr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    off_d    = off_q;
    isload_d = isload_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          dreq_d   = 1'b1;
          dwe_d    = MemWriteM;
          daddr_d  = {ALUResultM[WIDTH-1:2], 2'b00};
          dwdata_d = st_data;
          dstrb_d  = MemWriteM ? st_strb : 4'b0000;
          size_d   = Funct3M[1:0];
          sign_d   = ~Funct3M[2];
          off_d    = off;
          isload_d = MemReadM;
          cnt_d    = '0;
          buserr_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (DAck) begin
          rbuf_d  = DRData;
          dreq_d  = 1'b0;
          dwe_d   = 1'b0;
          dstrb_d = 4'b0000;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th request cycle without an acknowledge: give up.
          rbuf_d   = '0;
          dreq_d   = 1'b0;
          dwe_d    = 1'b0;
          dstrb_d  = 4'b0000;
          buserr_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        buserr_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dstrb_q  <= 4'b0000;
      rbuf_q   <= '0;
      cnt_q    <= '0;
      buserr_q <= 1'b0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      off_q    <= 2'b00;
      isload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dstrb_q  <= dstrb_d;
      rbuf_q   <= rbuf_d;
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      off_q    <= off_d;
      isload_q <= isload_d;
    end
  end

  logic [7:0]  rbytes [4];
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [WIDTH-1:0] ld_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbytes[gi] = rbuf_q[8*gi +: 8];
  end

  assign byte_v = rbytes[off_q];
  assign half_v = off_q[1] ? {rbytes[3], rbytes[2]} : {rbytes[1], rbytes[0]};

  always_comb begin
    case (size_q)
      SZ_BYTE: ld_ext = {{24{sign_q & byte_v[7]}}, byte_v};
      SZ_HALF: ld_ext = {{16{sign_q & half_v[15]}}, half_v};
      default: ld_ext = rbuf_q;
    endcase
  end

  assign ReadDataM = ((state_q == S_DONE) && isload_q && !buserr_q) ? ld_ext : '0;
  assign BusErrM   = buserr_q;
  assign DReq      = dreq_q;
  assign DWe       = dwe_q;
  assign DAddr     = daddr_q;
  assign DWData    = dwdata_q;
  assign DStrb     = dstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver queues expected bus beats and results,
// separate monitors compare them when the DUT starts/ends a bus beat or releases the stall.
`timescale 1ns/1ps

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [3:0]  DStrb;
  logic        DAck = 1'b0;
  logic [31:0] DRData = '0;

  mem_stage_lsu #(.WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DStrb(DStrb),
    .DAck(DAck), .DRData(DRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_wd;
    int          len;
  } bus_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mis;
    int          stalls;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int          ack_delay = -1;
  logic [31:0] resp_data = '0;
  bit          ack_pulse = 1'b0;
  int          req_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endfunction

  // Bus slave: acknowledges after ack_delay request cycles (never when negative).
  always @(negedge clk) begin
    if (DReq) begin
      DAck   = (req_cyc == ack_delay) || ack_pulse;
      DRData = resp_data;
      req_cyc++;
    end else begin
      DAck    = ack_pulse;
      DRData  = resp_data;
      req_cyc = 0;
    end
  end

  // Bus monitor: checks request fields on the first DReq cycle, length when DReq falls.
  bit prev_dreq = 1'b0;
  int beat_len = 0;
  always @(negedge clk) begin
    if (DReq && !prev_dreq) begin
      if (bus_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL bus_unexpected: got DReq addr 0x%08h required no request", DAddr);
      end else begin
        check("bus_we", 32'(DWe), 32'(bus_q[0].we));
        check("bus_addr", DAddr, bus_q[0].addr);
        check("bus_strb", 32'(DStrb), 32'(bus_q[0].strb));
        if (bus_q[0].chk_wd) check("bus_wdata", DWData, bus_q[0].wdata);
        $display("bus  beat: we=%0d addr=0x%08h wdata=0x%08h strb=%b", DWe, DAddr, DWData, DStrb);
      end
      beat_len = 0;
    end
    if (DReq) beat_len++;
    if (!DReq && prev_dreq && bus_q.size() != 0) begin
      check("bus_len", 32'(beat_len), 32'(bus_q[0].len));
      void'(bus_q.pop_front());
    end
    prev_dreq = DReq;
  end

  // Result monitor: the cycle an access is no longer stalled is the MEM/WB capture cycle.
  int stall_cnt = 0;
  always @(negedge clk) begin
    res_t e;
    if ((MemReadM || MemWriteM) && rst_n) begin
      if (StallM) begin
        stall_cnt++;
      end else begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL res_unexpected: got completion rd=0x%08h required none", ReadDataM);
        end else begin
          e = res_q.pop_front();
          check("rdata", ReadDataM, e.rd);
          check("buserr", 32'(BusErrM), 32'(e.err));
          check("misalign", 32'(MisalignM), 32'(e.mis));
          check("stalls", 32'(stall_cnt), 32'(e.stalls));
          $display("res  done: rd=0x%08h err=%0d mis=%0d stalls=%0d", ReadDataM, BusErrM, MisalignM, stall_cnt);
        end
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  task automatic do_op(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata, input int delay,
                       input bit bus_exp, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_strb, input int e_len,
                       input logic [31:0] e_rd, input bit e_err, input bit e_mis, input int e_stall);
    bus_t b;
    res_t r;
    int k;
    if (bus_exp) begin
      b.we = !rd; b.addr = e_addr; b.wdata = e_wdata; b.strb = e_strb;
      b.chk_wd = !rd; b.len = e_len;
      bus_q.push_back(b);
    end
    r.rd = e_rd; r.err = e_err; r.mis = e_mis; r.stalls = e_stall;
    res_q.push_back(r);
    ack_delay = delay;
    resp_data = rdata;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = !rd; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!StallM) break;
    end
    if (k == 1000) begin
      n_cmp++; n_err++;
      $display("FAIL op_bound: got StallM stuck for %0d cycles required release", k);
    end
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of run required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    int k;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dreq", 32'(DReq), 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_buserr", 32'(BusErrM), 32'd0);
    check("rst_daddr", DAddr, 32'd0);
    check("rst_dwdata", DWData, 32'd0);
    check("rst_dstrb", 32'(DStrb), 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_misalign", 32'(MisalignM), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //     rd f3      addr      wdata         rdata         dly bus addr     wdata         strb    len  rd            err mis stall
    do_op(1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  1, 32'h100, 32'h0,        4'b0000, 1,   32'hDEADBEEF, 0, 0, 2);
    do_op(1, 3'b000, 32'h103, 32'h0,        32'h80123456, 0,  1, 32'h100, 32'h0,        4'b0000, 1,   32'hFFFFFF80, 0, 0, 2);
    do_op(1, 3'b100, 32'h103, 32'h0,        32'h80123456, 0,  1, 32'h100, 32'h0,        4'b0000, 1,   32'h00000080, 0, 0, 2);
    do_op(0, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0,  1, 32'h100, 32'hABCDABCD, 4'b1100, 1,   32'h0,        0, 0, 2);
    do_op(1, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2,  1, 32'h100, 32'h0,        4'b0000, 3,   32'hFFFF8001, 0, 0, 4);
    do_op(1, 3'b101, 32'h100, 32'h0,        32'h8001F00D, 1,  1, 32'h100, 32'h0,        4'b0000, 2,   32'h0000F00D, 0, 0, 3);
    do_op(0, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0,  1, 32'h100, 32'hA5A5A5A5, 4'b0010, 1,   32'h0,        0, 0, 2);
    do_op(0, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        0,  1, 32'h104, 32'hCAFEF00D, 4'b1111, 1,   32'h0,        0, 0, 2);
    do_op(1, 3'b000, 32'h200, 32'h0,        32'h1234567F, 0,  1, 32'h200, 32'h0,        4'b0000, 1,   32'h0000007F, 0, 0, 2);
    do_op(1, 3'b000, 32'h202, 32'h0,        32'h00AB0000, 0,  1, 32'h200, 32'h0,        4'b0000, 1,   32'hFFFFFFAB, 0, 0, 2);
    do_op(1, 3'b010, 32'h300, 32'h0,        32'h99999999, -1, 1, 32'h300, 32'h0,        4'b0000, 255, 32'h0,        1, 0, 256);
    do_op(1, 3'b010, 32'h304, 32'h0,        32'h0BADF00D, 0,  1, 32'h304, 32'h0,        4'b0000, 1,   32'h0BADF00D, 0, 0, 2);

    // Reset in the middle of a request that is never acknowledged.
    b.we = 1'b0; b.addr = 32'h180; b.wdata = '0; b.strb = 4'b0000; b.chk_wd = 1'b0; b.len = 3;
    bus_q.push_back(b);
    ack_delay = -1;
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h180;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (DReq) break;
    end
    if (k == 10) begin
      n_cmp++; n_err++;
      $display("FAIL rst_req_bound: got no DReq required DReq within 10 cycles");
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0; MemReadM = 1'b0;
    #1;
    check("rstmid_dreq", 32'(DReq), 32'd0);
    check("rstmid_stall", 32'(StallM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    resp_data = 32'h77777777;
    ack_pulse = 1'b1;
    repeat (2) @(negedge clk);
    ack_pulse = 1'b0;
    check("lateack_dreq", 32'(DReq), 32'd0);
    check("lateack_stall", 32'(StallM), 32'd0);
    check("lateack_buserr", 32'(BusErrM), 32'd0);
    check("lateack_rdata", ReadDataM, 32'd0);
    repeat (2) @(negedge clk);
    do_op(1, 3'b010, 32'h400, 32'h0,        32'h11223344, 0,  1, 32'h400, 32'h0,        4'b0000, 1,   32'h11223344, 0, 0, 2);

`ifdef MISALIGN_TRAP_EN
    do_op(1, 3'b010, 32'h102, 32'h0,        32'h55667788, 0,  0, 32'h0,   32'h0,        4'b0000, 0,   32'h0,        0, 1, 0);
    do_op(0, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        0,  0, 32'h0,   32'h0,        4'b0000, 0,   32'h0,        0, 1, 0);
`else
    do_op(1, 3'b010, 32'h102, 32'h0,        32'h55667788, 0,  1, 32'h100, 32'h0,        4'b0000, 1,   32'h55667788, 0, 0, 2);
    do_op(0, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        0,  1, 32'h100, 32'hBEEFBEEF, 4'b0011, 1,   32'h0,        0, 0, 2);
`endif

    repeat (4) @(negedge clk);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
